// File: rtl/rr_stream_mux.sv
// N_CH-to-1 valid/ready stream mux with round-robin arbitration.
// A granted channel keeps the registered output lane until its last beat.
module rr_stream_mux #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int CH_W  = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH-1:0]       in_last,
  output logic [N_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  output logic                  out_last,
  output logic [CH_W-1:0]       out_ch,
  input  logic                  out_ready
);

  typedef enum logic {
    S_IDLE,
    S_LOCK
  } state_t;

  state_t           r_state;
  logic [CH_W-1:0]  r_ptr;
  logic [CH_W-1:0]  r_gnt;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_out_last;
  logic [CH_W-1:0]  r_out_ch;

  logic [CH_W:0]    w_idx;
  logic [CH_W-1:0]  w_srch;
  logic [CH_W-1:0]  w_sel;
  logic [CH_W-1:0]  w_ptr_nxt;
  logic [N_CH-1:0]  w_rdy;
  logic [WIDTH-1:0] w_data;
  logic             w_free;
  logic             w_any;
  logic             w_xfer;
  logic             w_last;

  // Walk downward so the lowest offset from r_ptr wins.
  always_comb begin
    w_srch = r_ptr;
    w_idx  = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      w_idx = {1'b0, r_ptr} + (CH_W+1)'(i);
      if (w_idx >= (CH_W+1)'(N_CH))
        w_idx = w_idx - (CH_W+1)'(N_CH);
      if (in_valid[w_idx[CH_W-1:0]])
        w_srch = w_idx[CH_W-1:0];
    end
  end

  assign w_free = !r_out_valid || out_ready;
  assign w_any  = |in_valid;
  assign w_sel  = (r_state == S_LOCK) ? r_gnt : w_srch;

  always_comb begin
    w_rdy = '0;
    if (rst_n && w_free && (r_state == S_LOCK || w_any))
      w_rdy[w_sel] = 1'b1;
  end

  assign w_xfer    = |(in_valid & w_rdy);
  assign w_last    = in_last[w_sel];
  assign w_data    = in_data[w_sel*WIDTH +: WIDTH];
  assign w_ptr_nxt = (w_sel == CH_W'(N_CH - 1)) ? '0 : w_sel + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_ch    <= '0;
    end else if (w_xfer) begin
      r_out_data  <= w_data;
      r_out_valid <= 1'b1;
      r_out_last  <= w_last;
      r_out_ch    <= w_sel;
      if (w_last) begin
        r_state <= S_IDLE;
        r_ptr   <= w_ptr_nxt;
      end else begin
        r_state <= S_LOCK;
        r_gnt   <= w_sel;
      end
    end else if (w_free) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_rdy;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed bench for rr_stream_mux: 4-channel and 3-channel instances,
// per-cycle expectations queued at drive time and popped after the edge.
module tb_rr_stream_mux;

  typedef struct packed {
    logic        v;
    logic [3:0]  ch;
    logic [15:0] d;
    logic        l;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] d4;
  logic [3:0]  v4, l4, rdy4;
  logic [7:0]  od4;
  logic        ov4, ol4, ordy4;
  logic [1:0]  och4;

  logic [47:0] d3;
  logic [2:0]  v3, l3, rdy3;
  logic [15:0] od3;
  logic        ov3, ol3, ordy3;
  logic [1:0]  och3;

  int n_vec = 0;
  int n_err = 0;
  exp_t q4[$];
  exp_t q3[$];

  rr_stream_mux #(.N_CH(4), .WIDTH(8)) u4 (
    .clk(clk), .rst_n(rst_n),
    .in_data(d4), .in_valid(v4), .in_last(l4),
    .in_ready(rdy4),
    .out_data(od4), .out_valid(ov4), .out_last(ol4),
    .out_ch(och4), .out_ready(ordy4)
  );

  rr_stream_mux #(.N_CH(3), .WIDTH(16)) u3 (
    .clk(clk), .rst_n(rst_n),
    .in_data(d3), .in_valid(v3), .in_last(l3),
    .in_ready(rdy3),
    .out_data(od3), .out_valid(ov3), .out_last(ol3),
    .out_ch(och3), .out_ready(ordy3)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc4(input logic [3:0] rdy, input logic v,
                      input logic [3:0] ch, input logic [15:0] d,
                      input logic l);
    exp_t e;
    #1;
    chk("rdy4", rdy4, rdy);
    q4.push_back('{v: v, ch: ch, d: d, l: l});
    @(posedge clk);
    #1;
    e = q4.pop_front();
    chk("valid4", ov4, e.v);
    if (e.v) begin
      chk("ch4", och4, e.ch);
      chk("data4", od4, e.d);
      chk("last4", ol4, e.l);
    end
  endtask

  task automatic cyc3(input logic [2:0] rdy, input logic [3:0] ch,
                      input logic [15:0] d);
    exp_t e;
    #1;
    chk("rdy3", rdy3, rdy);
    q3.push_back('{v: 1'b1, ch: ch, d: d, l: 1'b1});
    @(posedge clk);
    #1;
    e = q3.pop_front();
    chk("valid3", ov3, e.v);
    chk("ch3", och3, e.ch);
    chk("data3", od3, e.d);
    chk("last3", ol3, e.l);
  endtask

  initial begin
    d4 = {8'h13, 8'h12, 8'h11, 8'h10};
    v4 = 4'b1111;
    l4 = 4'b1111;
    ordy4 = 1'b1;
    d3 = '0;
    v3 = 3'b000;
    l3 = 3'b111;
    ordy3 = 1'b1;

    // Reset state, with valid presented during reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", ov4, 1'b0);
    chk("rst_data", od4, 8'h00);
    chk("rst_ch", och4, 2'd0);
    chk("rst_last", ol4, 1'b0);
    chk("rst_rdy", rdy4, 4'b0000);
    rst_n = 1'b1;

    // Round robin, single-beat packets, no bubbles
    for (int k = 0; k < 6; k++)
      cyc4(4'b0001 << (k % 4), 1'b1, 4'(k % 4),
           16'(8'h10 + (k % 4)), 1'b1);

    // Channel 2 three-beat packet locks the lane
    d4[16 +: 8] = 8'h21;
    l4[2] = 1'b0;
    cyc4(4'b0100, 1'b1, 4'd2, 16'h21, 1'b0);
    d4[16 +: 8] = 8'h22;
    cyc4(4'b0100, 1'b1, 4'd2, 16'h22, 1'b0);
    d4[16 +: 8] = 8'h23;
    l4[2] = 1'b1;
    cyc4(4'b0100, 1'b1, 4'd2, 16'h23, 1'b1);
    d4[16 +: 8] = 8'h12;
    cyc4(4'b1000, 1'b1, 4'd3, 16'h13, 1'b1);

    // Backpressure holds 0x55
    d4[0 +: 8] = 8'h55;
    cyc4(4'b0001, 1'b1, 4'd0, 16'h55, 1'b1);
    d4[0 +: 8] = 8'h10;
    ordy4 = 1'b0;
    repeat (5) cyc4(4'b0000, 1'b1, 4'd0, 16'h55, 1'b1);
    ordy4 = 1'b1;
    cyc4(4'b0010, 1'b1, 4'd1, 16'h11, 1'b1);

    // Locked channel 1 stalls; channel 0 must wait
    v4 = 4'b0010;
    l4 = 4'b1101;
    d4[8 +: 8] = 8'h31;
    cyc4(4'b0010, 1'b1, 4'd1, 16'h31, 1'b0);
    v4 = 4'b0001;
    repeat (3) cyc4(4'b0010, 1'b0, 4'd0, 16'h0, 1'b0);
    v4 = 4'b0011;
    l4 = 4'b1111;
    d4[8 +: 8] = 8'h32;
    cyc4(4'b0010, 1'b1, 4'd1, 16'h32, 1'b1);
    v4 = 4'b0001;
    d4[8 +: 8] = 8'h11;
    cyc4(4'b0001, 1'b1, 4'd0, 16'h10, 1'b1);

    // Asynchronous reset mid-packet on channel 3
    v4 = 4'b1000;
    l4 = 4'b0111;
    d4[24 +: 8] = 8'h41;
    cyc4(4'b1000, 1'b1, 4'd3, 16'h41, 1'b0);
    v4 = 4'b1001;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", ov4, 1'b0);
    chk("arst_rdy", rdy4, 4'b0000);
    chk("arst_data", od4, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    l4 = 4'b1111;
    d4[24 +: 8] = 8'h13;
    cyc4(4'b0001, 1'b1, 4'd0, 16'h10, 1'b1);
    cyc4(4'b1000, 1'b1, 4'd3, 16'h13, 1'b1);
    v4 = 4'b0000;
    cyc4(4'b0000, 1'b0, 4'd0, 16'h0, 1'b0);

    // Three channels, sixteen bits, wrap from channel 2
    v3 = 3'b100;
    d3[0 +: 16] = 16'h0A0A;
    d3[16 +: 16] = 16'h1B1B;
    for (int k = 0; k < 4; k++) begin
      d3[32 +: 16] = 16'hC000 + 16'(k);
      cyc3(3'b100, 4'd2, 16'hC000 + 16'(k));
    end
    v3 = 3'b111;
    d3[32 +: 16] = 16'hC2C2;
    cyc3(3'b001, 4'd0, 16'h0A0A);
    cyc3(3'b010, 4'd1, 16'h1B1B);
    cyc3(3'b100, 4'd2, 16'hC2C2);
    cyc3(3'b001, 4'd0, 16'h0A0A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rr_stream_mux.md
# rr_stream_mux

Parametrised N-channel stream multiplexer with valid/ready handshake, round-robin arbitration and packet lock. It is the next generation of the team's 2:1 select mux. N_CH producer channels share one registered output lane. A channel, once granted, keeps the lane until its `last` beat is accepted, so packets are never interleaved. Sits between per-channel packet sources and a single downstream consumer.

## Interface
Parameters:
- `N_CH`, 4: number of input channels; legal range 2..16.
- `WIDTH`, 8: data bits per beat.
- `CH_W`, $clog2(N_CH): channel index width; derived, not overridden.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: asynchronous reset, active-low; deassertion is synchronous to `clk` upstream of this block.
- `in_data` input N_CH*WIDTH: channel c occupies bits [c*WIDTH +: WIDTH].
- `in_valid` input N_CH: per-channel beat valid.
- `in_last` input N_CH: per-channel end-of-packet flag; qualified by `in_valid`.
- `in_ready` output N_CH: per-channel accept; at most one bit high in any cycle.
- `out_data` output WIDTH: registered output beat.
- `out_valid` output 1: registered output valid.
- `out_last` output 1: registered end-of-packet flag.
- `out_ch` output CH_W: registered source channel of the current output beat.
- `out_ready` input 1: downstream accept.

## Operation
- Output register is free when `out_valid`=0 or `out_ready`=1 (`free`).
- States:
  - IDLE: no channel owns the lane.
  - LOCK: channel `gnt` owns the lane.
- Selection (`sel`):
  - In IDLE: first channel with `in_valid` high, searching upward from `ptr` with wrap (`ptr`, `ptr`+1, …, N_CH-1, 0, …).
  - In LOCK: `sel` = `gnt`.
- `in_ready[c]` = `free` AND (c == `sel`) AND (state == LOCK OR any `in_valid`). Otherwise 0.
  - In IDLE, `in_ready` is high only toward a channel that is presenting valid.
  - The path from `out_ready` to `in_ready` is combinational by design.
- Transfer on channel c: `in_valid[c]` AND `in_ready[c]` at a rising edge. The output register loads `in_data[c]` and `in_last[c]`, `out_ch`<=c, `out_valid`<=1.
- If `free` and no transfer occurs, `out_valid`<=0. `out_data`, `out_last` and `out_ch` hold their last values.
- IDLE -> LOCK on a transfer whose `in_last`=0. Set `gnt`<=c.
- IDLE -> IDLE on a transfer whose `in_last`=1 (single-beat packet). Set `ptr`<=(c+1) mod N_CH.
- LOCK -> IDLE on a transfer with `in_last`=1. Set `ptr`<=(`gnt`+1) mod N_CH.
- LOCK otherwise holds. Valid on other channels is ignored and their `in_ready` stays 0.
- A locked channel may drop `in_valid` mid-packet. The lock is held indefinitely; there is no timeout.
- Wrap: `ptr` and the search index wrap modulo N_CH. N_CH need not be a power of two.
- Reset (`rst_n` low, any time including mid-packet):
  - `out_valid`=0, `out_last`=0, `out_data`=0, `out_ch`=0, state=IDLE, `ptr`=0, `gnt`=0.
  - `in_ready` forced all-zero while `rst_n` is low.
  - A partial packet is discarded. No recovery is attempted.

## Timing
- Latency is one cycle: a beat accepted at edge k appears on `out_*` immediately after edge k.
- Throughput is 1 beat/cycle with `out_ready` held high, including back-to-back packets on different channels.
- The IDLE arbitration after a `last` beat costs no bubble.
- When `out_ready`=0 and `out_valid`=1, all `in_ready`=0 and `out_*` are stable until accepted.
- The first clock edge after `rst_n` rises may accept a beat.

## Test plan
- Reset, then all four channels valid with single-beat packets and `out_ready`=1. Required `out_ch` sequence: 0,1,2,3,0,… on consecutive cycles, with `out_valid` continuously 1.
- Channel 2 sends a 3-beat packet (`in_data` 0x21, 0x22, 0x23, `last` on the 3rd) while channels 0, 1 and 3 stay valid. Required: `out_data` 0x21, 0x22, 0x23 all with `out_ch`=2; the next packet comes from channel 3; `in_ready[0,1,3]` stays 0 throughout the lock.
- Backpressure: `out_ready`=0 for 5 cycles while `out_valid`=1 with data 0x55. Required: `out_data` holds 0x55 and `in_ready`=0000. After `out_ready` rises, the next beat appears one cycle later.
- Locked channel 1 drops `in_valid` for 3 cycles mid-packet while channel 0 is valid. Required: `out_valid`=0 in those cycles and no channel-0 beat is emitted until channel 1's `last` beat is accepted.
- Assert `rst_n`=0 mid-packet on channel 3. Required: `out_valid`=0 and `in_ready`=0000 immediately (asynchronous). After release with channels 0 and 3 valid, channel 0 is granted first (`ptr`=0).
- N_CH=3, WIDTH=16, only channel 2 valid with single-beat packets. Required: `out_ch`=2 every cycle, and the next IDLE search after each packet starts at channel 0 (wrap from 2).
